hdr_ddr_mode_ctrl: RTL and testbench
====================================

Name: hdr_ddr_mode_ctrl

Overview:
- Responder to the HDR engine's HDR-mode enable/done handshake: on enable, executes one I3C HDR-DDR transfer (command word, write or read data words, CRC word, restart/exit pattern), then returns done.
- Sits between the HDR engine and the SDA/SCL serializer/deserializer pair.
- Handles only parallel 20-bit DDR words; bit timing belongs to the PHY/serializer.

Parameters:
- LEN_W, 8, width of data-word count.
- CRC_INIT, 5'b11111, CRC5 seed.

Ports:
- i_sys_clk  in  1  system clock
- i_sys_rst_n  in  1  async active-low reset
- i_hdrmode_en  in  1  level enable from HDR engine; held until done observed
- i_TOC  in  1  term of completion: 1 = exit pattern, 0 = restart pattern
- i_rnw  in  1  1 = read, 0 = write
- i_cmd_code  in  7  HDR command code
- i_target_addr  in  7  dynamic address
- i_data_len  in  LEN_W  number of 16-bit data words, 0 allowed
- i_tx_data  in  16  write payload, valid when o_tx_data_rd pulses
- o_tx_data_rd  out  1  one-cycle pop of next write payload
- o_word  out  20  DDR word to serializer {preamble[1:0], payload[15:0], parity[1:0]}
- o_word_valid  out  1  word offered
- i_word_ready  in  1  serializer accepts word when valid&ready
- i_rx_word  in  20  word from deserializer
- i_rx_valid  in  1  rx word strobe, one cycle
- o_rx_data  out  16  read payload
- o_rx_data_valid  out  1  one-cycle strobe per good read word
- o_restart_req  out  1  one-cycle request for restart pattern
- o_exit_req  out  1  one-cycle request for exit pattern
- i_pattern_done  in  1  PHY finished restart/exit pattern
- o_hdr_mode_done  out  1  transfer complete; level
- o_err_status  out  3  sticky: [0] rx parity, [1] CRC mismatch, [2] rx preamble/abort

Behaviour:
- Reset: all outputs 0; state IDLE; CRC = CRC_INIT; word counter 0.
- States: IDLE, CMD, WR_DATA, RD_DATA, CRC_TX, CRC_RX, TERM, DONE.
- IDLE: on i_hdrmode_en rising (en=1, done=0), latch i_TOC, i_rnw, code, addr, len; clear o_err_status and CRC; go to CMD.
- CMD:
  - o_word = {2'b01, rnw, code, addr, pa_adj, PA1, PA0}.
  - Parity: PA1 = XOR of payload odd bits; PA0 = XOR of even bits ^ 1.
  - pa_adj = 1 when needed so PA0 = 1 for a read; otherwise 0.
  - Hold o_word_valid until ready, then update CRC over the payload.
  - Next state: write with len>0 -> WR_DATA; write with len=0 -> CRC_TX; read -> RD_DATA.
- WR_DATA:
  - o_tx_data_rd pulses for one cycle on state entry and after each accepted word.
  - The following cycle presents {2'b10, data, PA1, PA0}.
  - After the len-th accept -> CRC_TX.
- CRC_TX: o_word = {2'b01, 4'hC, crc[4:0], 9'b0}; on accept -> TERM.
- RD_DATA:
  - Each i_rx_valid word with preamble 2'b10: check parity (mismatch sets err[0]), update CRC, pulse o_rx_data_valid with payload.
  - A word with preamble 2'b01 and payload[15:12] = 4'hC -> CRC_RX handling in the same cycle: compare payload[11:7] to CRC; mismatch sets err[1]; go to TERM.
  - Any other preamble, or more than len data words, sets err[2] and goes to TERM.
- TERM: pulse o_exit_req if latched TOC=1, else o_restart_req; wait for i_pattern_done; go to DONE.
- DONE: o_hdr_mode_done = 1 until i_hdrmode_en = 0, then IDLE. Minimum enable-to-done latency is 3 cycles (len=0 write, ready tied high, pattern_done immediate).
- CRC5: polynomial x^5+x^2+1, MSB-first over each 16-bit payload, updated in a single cycle.
- i_hdrmode_en dropping mid-transfer (abort): finish the current word handshake, skip remaining data, go to TERM with exit forced, set err[2].
- i_word_ready held low: o_word and o_word_valid stay stable, with no timeout.
- i_rx_valid outside RD_DATA is ignored.
- Async reset mid-transfer returns to IDLE immediately with no pattern request.

Decomposition:
- Shared package hdr_ddr_pkg holds:
  - preamble constants PRE_CMD = 2'b01, PRE_DATA = 2'b10;
  - CRC token 4'hC;
  - CRC_POLY;
  - the state encoding;
  - a parity function and a crc5_update function.
- One natural sub-module, hdr_ddr_crc5: seed, clear, 16-bit update, 5-bit result. It is shared with the future target-side block.

Test Plan:
- Write, code 7'h20, addr 7'h08, len 2, data 16'hA5A5 then 16'h0001, TOC=1:
  - expect the command word, then two data words with preamble 10 and correct parity;
  - then the CRC word matching the reference model;
  - then one o_exit_req pulse;
  - done after pattern_done.
- Read, len 3, TOC=0:
  - inject 3 good data words plus a correct CRC word;
  - expect 3 o_rx_data_valid strobes, err = 0, one o_restart_req pulse.
- Read with word 2 parity flipped and a bad CRC -> err = 3'b011 and data still delivered.
- Write, len 0, ready tied high -> only command and CRC words, done 3 cycles after enable.
- Backpressure: i_word_ready low for 10 cycles on the data word -> o_word stable, no extra o_tx_data_rd.
- Abort: drop i_hdrmode_en after the command word -> exit request, err[2] = 1. Separately, assert reset mid-RD_DATA -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/hdr_ddr_pkg.sv
// Shared HDR-DDR definitions: word preambles, CRC token/polynomial, controller
// state encoding, and the parity and CRC5 helpers used by controller and target.
package hdr_ddr_pkg;

  localparam logic [1:0] PRE_CMD   = 2'b01;
  localparam logic [1:0] PRE_DATA  = 2'b10;
  localparam logic [3:0] CRC_TOKEN = 4'hC;
  localparam logic [4:0] CRC_POLY  = 5'b00101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_CRC_TX,
    ST_CRC_RX,
    ST_TERM,
    ST_DONE
  } state_e;

  // {PA1, PA0}: PA1 covers odd payload bits, PA0 covers even bits and is inverted
  function automatic logic [1:0] ddr_parity(input logic [15:0] payload);
    logic odd_x;
    logic even_x;
    odd_x  = 1'b0;
    even_x = 1'b0;
    for (int i = 0; i < 16; i += 2) begin
      even_x ^= payload[i];
      odd_x  ^= payload[i+1];
    end
    return {odd_x, even_x ^ 1'b1};
  endfunction

  // x^5 + x^2 + 1, payload shifted in MSB first
  function automatic logic [4:0] crc5_update(input logic [4:0] crc, input logic [15:0] data);
    logic [4:0] c;
    logic       fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[4] ^ data[i];
      c  = {c[3:0], 1'b0} ^ (fb ? CRC_POLY : 5'b00000);
    end
    return c;
  endfunction

endpackage

// File: rtl/hdr_ddr_crc5.sv
// CRC5 accumulator for HDR-DDR payloads: loads the seed on clear, folds one
// 16-bit payload per update cycle.
module hdr_ddr_crc5
  import hdr_ddr_pkg::*;
#(
  parameter logic [4:0] CRC_INIT = 5'b11111
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst_n,
  input  logic        i_clear,
  input  logic        i_update,
  input  logic [15:0] i_data,
  output logic [4:0]  o_crc
);

  logic [4:0] crc_q;
  logic [4:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (i_clear) begin
      crc_d = CRC_INIT;
    end else if (i_update) begin
      crc_d = crc5_update(crc_q, i_data);
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/hdr_ddr_mode_ctrl.sv
// HDR-DDR controller-side transfer sequencer: answers the HDR engine's enable with
// one command / data / CRC / terminate sequence at 20-bit word granularity.
module hdr_ddr_mode_ctrl
  import hdr_ddr_pkg::*;
#(
  parameter int         LEN_W    = 8,
  parameter logic [4:0] CRC_INIT = 5'b11111
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rst_n,
  input  logic             i_hdrmode_en,
  input  logic             i_TOC,
  input  logic             i_rnw,
  input  logic [6:0]       i_cmd_code,
  input  logic [6:0]       i_target_addr,
  input  logic [LEN_W-1:0] i_data_len,
  input  logic [15:0]      i_tx_data,
  output logic             o_tx_data_rd,
  output logic [19:0]      o_word,
  output logic             o_word_valid,
  input  logic             i_word_ready,
  input  logic [19:0]      i_rx_word,
  input  logic             i_rx_valid,
  output logic [15:0]      o_rx_data,
  output logic             o_rx_data_valid,
  output logic             o_restart_req,
  output logic             o_exit_req,
  input  logic             i_pattern_done,
  output logic             o_hdr_mode_done,
  output logic [2:0]       o_err_status
);

  state_e           state_q, state_d;
  logic             toc_q, toc_d;
  logic             rnw_q, rnw_d;
  logic [6:0]       code_q, code_d;
  logic [6:0]       addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             fetch_q, fetch_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             req_q, req_d;
  logic [2:0]       err_q, err_d;
  logic [15:0]      rx_data_q, rx_data_d;
  logic             rx_vld_q, rx_vld_d;

  logic             crc_clr;
  logic             crc_upd;
  logic [15:0]      crc_din;
  logic [4:0]       crc;

  logic [15:0]      cmd_nopa;
  logic             pa_adj;
  logic [15:0]      cmd_payload;
  logic [LEN_W-1:0] cnt_inc;
  logic [1:0]       rx_pre;
  logic [15:0]      rx_pay;
  logic             go_term;
  logic             abort;

  // A read command steers its spare bit so that PA0 of the command word is 1
  assign cmd_nopa    = {rnw_q, code_q, addr_q, 1'b0};
  assign pa_adj      = rnw_q & (^(cmd_nopa & 16'h5555));
  assign cmd_payload = {rnw_q, code_q, addr_q, pa_adj};
  assign cnt_inc     = cnt_q + LEN_W'(1);
  assign rx_pre      = i_rx_word[19:18];
  assign rx_pay      = i_rx_word[17:2];

  hdr_ddr_crc5 #(
    .CRC_INIT (CRC_INIT)
  ) u_crc (
    .i_sys_clk   (i_sys_clk),
    .i_sys_rst_n (i_sys_rst_n),
    .i_clear     (crc_clr),
    .i_update    (crc_upd),
    .i_data      (crc_din),
    .o_crc       (crc)
  );

  always_comb begin
    state_d         = state_q;
    toc_d           = toc_q;
    rnw_d           = rnw_q;
    code_d          = code_q;
    addr_d          = addr_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    fetch_d         = fetch_q;
    wdata_d         = wdata_q;
    req_d           = req_q;
    err_d           = err_q;
    rx_data_d       = rx_data_q;
    rx_vld_d        = 1'b0;
    crc_clr         = 1'b0;
    crc_upd         = 1'b0;
    crc_din         = 16'h0000;
    o_word          = 20'h00000;
    o_word_valid    = 1'b0;
    o_tx_data_rd    = 1'b0;
    o_restart_req   = 1'b0;
    o_exit_req      = 1'b0;
    o_hdr_mode_done = 1'b0;
    go_term         = 1'b0;
    abort           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_hdrmode_en) begin
          toc_d   = i_TOC;
          rnw_d   = i_rnw;
          code_d  = i_cmd_code;
          addr_d  = i_target_addr;
          len_d   = i_data_len;
          cnt_d   = '0;
          err_d   = 3'b000;
          crc_clr = 1'b1;
          state_d = ST_CMD;
        end
      end

      ST_CMD: begin
        o_word       = {PRE_CMD, cmd_payload, ddr_parity(cmd_payload)};
        o_word_valid = 1'b1;
        if (i_word_ready) begin
          crc_upd = 1'b1;
          crc_din = cmd_payload;
          if (!i_hdrmode_en) begin
            abort   = 1'b1;
            go_term = 1'b1;
          end else if (rnw_q) begin
            state_d = ST_RD_DATA;
          end else if (len_q == '0) begin
            state_d = ST_CRC_TX;
          end else begin
            fetch_d = 1'b1;
            state_d = ST_WR_DATA;
          end
        end
      end

      // Alternates a one-cycle payload pop with presenting that payload
      ST_WR_DATA: begin
        if (fetch_q) begin
          if (!i_hdrmode_en) begin
            abort   = 1'b1;
            go_term = 1'b1;
          end else begin
            o_tx_data_rd = 1'b1;
            wdata_d      = i_tx_data;
            fetch_d      = 1'b0;
          end
        end else begin
          o_word       = {PRE_DATA, wdata_q, ddr_parity(wdata_q)};
          o_word_valid = 1'b1;
          if (i_word_ready) begin
            crc_upd = 1'b1;
            crc_din = wdata_q;
            cnt_d   = cnt_inc;
            if (!i_hdrmode_en) begin
              abort   = 1'b1;
              go_term = 1'b1;
            end else if (cnt_inc == len_q) begin
              state_d = ST_CRC_TX;
            end else begin
              fetch_d = 1'b1;
            end
          end
        end
      end

      ST_RD_DATA: begin
        if (!i_hdrmode_en) begin
          abort   = 1'b1;
          go_term = 1'b1;
        end else if (i_rx_valid) begin
          if (rx_pre == PRE_DATA && cnt_q != len_q) begin
            if (ddr_parity(rx_pay) != i_rx_word[1:0]) begin
              err_d[0] = 1'b1;
            end
            crc_upd   = 1'b1;
            crc_din   = rx_pay;
            cnt_d     = cnt_inc;
            rx_vld_d  = 1'b1;
            rx_data_d = rx_pay;
          end else if (rx_pre == PRE_CMD && rx_pay[15:12] == CRC_TOKEN) begin
            if (rx_pay[11:7] != crc) begin
              err_d[1] = 1'b1;
            end
            go_term = 1'b1;
          end else begin
            err_d[2] = 1'b1;
            go_term  = 1'b1;
          end
        end
      end

      ST_CRC_TX: begin
        o_word       = {PRE_CMD, CRC_TOKEN, crc, 9'b0};
        o_word_valid = 1'b1;
        if (i_word_ready) begin
          go_term = 1'b1;
        end
      end

      ST_TERM: begin
        o_exit_req    = req_q & toc_q;
        o_restart_req = req_q & ~toc_q;
        req_d         = 1'b0;
        if (i_pattern_done) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        o_hdr_mode_done = 1'b1;
        if (!i_hdrmode_en) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort always ends with the exit pattern, whatever TOC the engine asked for
    if (abort) begin
      toc_d    = 1'b1;
      err_d[2] = 1'b1;
    end
    if (go_term) begin
      req_d   = 1'b1;
      state_d = ST_TERM;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q   <= ST_IDLE;
      toc_q     <= 1'b0;
      rnw_q     <= 1'b0;
      code_q    <= 7'h00;
      addr_q    <= 7'h00;
      len_q     <= '0;
      cnt_q     <= '0;
      fetch_q   <= 1'b0;
      wdata_q   <= 16'h0000;
      req_q     <= 1'b0;
      err_q     <= 3'b000;
      rx_data_q <= 16'h0000;
      rx_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      toc_q     <= toc_d;
      rnw_q     <= rnw_d;
      code_q    <= code_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      fetch_q   <= fetch_d;
      wdata_q   <= wdata_d;
      req_q     <= req_d;
      err_q     <= err_d;
      rx_data_q <= rx_data_d;
      rx_vld_q  <= rx_vld_d;
    end
  end

  assign o_rx_data       = rx_data_q;
  assign o_rx_data_valid = rx_vld_q;
  assign o_err_status    = err_q;

endmodule

// File: tb/tb_hdr_ddr_mode_ctrl.sv
// Directed bench for hdr_ddr_mode_ctrl: write, read, zero-length, backpressure,
// abort and reset scenarios against hand-computed words and a small CRC5 model.
module tb_hdr_ddr_mode_ctrl;
  import hdr_ddr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        toc;
  logic        rnw;
  logic [6:0]  code;
  logic [6:0]  addr;
  logic [7:0]  len;
  logic [15:0] tx_data;
  logic        tx_rd;
  logic [19:0] word;
  logic        word_valid;
  logic        ready;
  logic [19:0] rx_word;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_data_valid;
  logic        restart_req;
  logic        exit_req;
  logic        pdone;
  logic        done;
  logic [2:0]  err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hdr_ddr_mode_ctrl #(.LEN_W(8), .CRC_INIT(5'b11111)) dut (
    .i_sys_clk       (clk),
    .i_sys_rst_n     (rst_n),
    .i_hdrmode_en    (en),
    .i_TOC           (toc),
    .i_rnw           (rnw),
    .i_cmd_code      (code),
    .i_target_addr   (addr),
    .i_data_len      (len),
    .i_tx_data       (tx_data),
    .o_tx_data_rd    (tx_rd),
    .o_word          (word),
    .o_word_valid    (word_valid),
    .i_word_ready    (ready),
    .i_rx_word       (rx_word),
    .i_rx_valid      (rx_valid),
    .o_rx_data       (rx_data),
    .o_rx_data_valid (rx_data_valid),
    .o_restart_req   (restart_req),
    .o_exit_req      (exit_req),
    .i_pattern_done  (pdone),
    .o_hdr_mode_done (done),
    .o_err_status    (err)
  );

  function automatic logic [4:0] tb_crc5(input logic [4:0] seed, input logic [15:0] d);
    logic [4:0] r;
    logic       fb;
    r = seed;
    for (int b = 15; b >= 0; b--) begin
      fb = r[4] ^ d[b];
      r  = {r[3], r[2], r[1] ^ fb, r[0], fb};
    end
    return r;
  endfunction

  function automatic logic [1:0] tb_par(input logic [15:0] p);
    return {^(p & 16'hAAAA), ~^(p & 16'h5555)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; toc = 1'b0; rnw = 1'b0; code = 7'h00; addr = 7'h00;
    len = 8'd0; tx_data = 16'h0000; ready = 1'b0; rx_word = 20'h0; rx_valid = 1'b0; pdone = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({word_valid, word, tx_rd, rx_data, rx_data_valid, restart_req, exit_req, done, err} !== 45'd0) begin
      n_fail++; $display("FAIL reset_outputs: got word=%h vld=%b err=%b done=%b, required all zero", word, word_valid, err, done);
    end
    n_checks++;
    if (dut.state_q !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d required %0d", dut.state_q, ST_IDLE);
    end
    n_checks++;
    if (dut.u_crc.crc_q !== 5'h1F || dut.cnt_q !== 8'd0) begin
      n_fail++; $display("FAIL reset_crc_cnt: got crc=%h cnt=%0d required crc=1f cnt=0", dut.u_crc.crc_q, dut.cnt_q);
    end
    rst_n = 1'b1;
    tick;
    n_checks++;
    if ({word_valid, tx_rd, done} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_reset: got vld=%b rd=%b done=%b required 0", word_valid, tx_rd, done);
    end
  endtask

  task automatic test_write;
    logic [4:0] c;
    c = tb_crc5(5'h1F, 16'h2010);
    c = tb_crc5(c, 16'hA5A5);
    c = tb_crc5(c, 16'h0001);
    toc = 1'b1; rnw = 1'b0; code = 7'h20; addr = 7'h08; len = 8'd2; ready = 1'b1; pdone = 1'b0;
    en = 1'b1;
    tick;
    n_checks++;
    if ({word_valid, word} !== {1'b1, 20'h48042}) begin
      n_fail++; $display("FAIL wr_cmd_word: got %b/%h required 1/48042", word_valid, word);
    end
    tick;
    n_checks++;
    if ({tx_rd, word_valid} !== 2'b10) begin
      n_fail++; $display("FAIL wr_pop0: got rd=%b vld=%b required rd=1 vld=0", tx_rd, word_valid);
    end
    tx_data = 16'hA5A5;
    tick;
    n_checks++;
    if ({tx_rd, word_valid, word} !== {2'b01, 20'hA9695}) begin
      n_fail++; $display("FAIL wr_data0_word: got rd=%b %b/%h required rd=0 1/a9695", tx_rd, word_valid, word);
    end
    tick;
    n_checks++;
    if (tx_rd !== 1'b1) begin
      n_fail++; $display("FAIL wr_pop1: got %b required 1", tx_rd);
    end
    tx_data = 16'h0001;
    tick;
    n_checks++;
    if ({word_valid, word} !== {1'b1, 20'h80004}) begin
      n_fail++; $display("FAIL wr_data1_word: got %b/%h required 1/80004", word_valid, word);
    end
    tick;
    n_checks++;
    if ({word_valid, word} !== {1'b1, 2'b01, 4'hC, c, 9'b0}) begin
      n_fail++; $display("FAIL wr_crc_word: got %b/%h required 1/%h", word_valid, word, {2'b01, 4'hC, c, 9'b0});
    end
    tick;
    n_checks++;
    if ({exit_req, restart_req, word_valid, done} !== 4'b1000) begin
      n_fail++; $display("FAIL wr_term: got exit=%b restart=%b vld=%b done=%b required 1000", exit_req, restart_req, word_valid, done);
    end
    pdone = 1'b1;
    tick;
    n_checks++;
    if ({done, exit_req, err} !== 5'b10000) begin
      n_fail++; $display("FAIL wr_done: got done=%b exit=%b err=%b required 1 0 000", done, exit_req, err);
    end
    en = 1'b0; pdone = 1'b0;
    tick;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL wr_release: got done=%b required 0", done);
    end
  endtask

  task automatic test_read(input logic bad);
    logic [15:0] d [3];
    logic [19:0] w;
    logic [4:0]  c;
    int          strobes;
    d[0] = 16'h1234; d[1] = 16'hBEEF; d[2] = 16'h0F0F;
    c = tb_crc5(5'h1F, 16'hA011);
    for (int k = 0; k < 3; k++) c = tb_crc5(c, d[k]);
    strobes = 0;
    toc = bad; rnw = 1'b1; code = 7'h20; addr = 7'h08; len = 8'd3; ready = 1'b1; pdone = 1'b0;
    en = 1'b1;
    tick;
    n_checks++;
    if ({word_valid, word} !== {1'b1, 20'h68045}) begin
      n_fail++; $display("FAIL rd_cmd_word: got %b/%h required 1/68045", word_valid, word);
    end
    // Word strobed before the command is accepted must not count as read data
    ready = 1'b0; rx_word = {2'b10, 16'h5A5A, tb_par(16'h5A5A)}; rx_valid = 1'b1;
    tick;
    rx_valid = 1'b0; ready = 1'b1;
    tick;
    n_checks++;
    if (rx_data_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_ignore_early: got strobe=%b required 0", rx_data_valid);
    end
    for (int k = 0; k < 3; k++) begin
      w = {2'b10, d[k], tb_par(d[k])};
      if (bad && k == 1) w[0] = ~w[0];
      rx_word = w; rx_valid = 1'b1;
      tick;
      strobes += int'(rx_data_valid);
      n_checks++;
      if ({rx_data_valid, rx_data} !== {1'b1, d[k]}) begin
        n_fail++; $display("FAIL rd_data%0d: got %b/%h required 1/%h", k, rx_data_valid, rx_data, d[k]);
      end
    end
    rx_word = {2'b01, 4'hC, (bad ? (c ^ 5'h01) : c), 9'b0}; rx_valid = 1'b1;
    tick;
    rx_valid = 1'b0;
    strobes += int'(rx_data_valid);
    n_checks++;
    if (strobes !== 3) begin
      n_fail++; $display("FAIL rd_strobe_count: got %0d required 3", strobes);
    end
    n_checks++;
    if (err !== (bad ? 3'b011 : 3'b000)) begin
      n_fail++; $display("FAIL rd_err: got %b required %b", err, (bad ? 3'b011 : 3'b000));
    end
    n_checks++;
    if ({exit_req, restart_req} !== (bad ? 2'b10 : 2'b01)) begin
      n_fail++; $display("FAIL rd_term_req: got exit=%b restart=%b required %b", exit_req, restart_req, (bad ? 2'b10 : 2'b01));
    end
    pdone = 1'b1;
    tick;
    n_checks++;
    if ({done, exit_req, restart_req} !== 3'b100) begin
      n_fail++; $display("FAIL rd_done: got done=%b exit=%b restart=%b required 100", done, exit_req, restart_req);
    end
    en = 1'b0; pdone = 1'b0;
    tick;
  endtask

  task automatic test_len0;
    logic [19:0] words [4];
    int          nwords;
    int          done_at;
    nwords = 0; done_at = 0;
    toc = 1'b1; rnw = 1'b0; code = 7'h05; addr = 7'h33; len = 8'd0; ready = 1'b1; pdone = 1'b1;
    en = 1'b1;
    // First edge captures enable; done is due three edges after that
    for (int i = 1; i <= 6; i++) begin
      tick;
      if (word_valid && nwords < 4) begin words[nwords] = word; nwords++; end
      if (done && done_at == 0) done_at = i;
    end
    n_checks++;
    if (nwords !== 2) begin
      n_fail++; $display("FAIL len0_word_count: got %0d required 2", nwords);
    end
    n_checks++;
    if (words[0] !== 20'h41599) begin
      n_fail++; $display("FAIL len0_cmd_word: got %h required 41599", words[0]);
    end
    n_checks++;
    if (words[1] !== {2'b01, 4'hC, tb_crc5(5'h1F, 16'h0566), 9'b0}) begin
      n_fail++; $display("FAIL len0_crc_word: got %h required %h", words[1], {2'b01, 4'hC, tb_crc5(5'h1F, 16'h0566), 9'b0});
    end
    n_checks++;
    if (done_at !== 4) begin
      n_fail++; $display("FAIL len0_latency: got done on edge %0d required edge 4", done_at);
    end
    en = 1'b0; pdone = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    logic [20:0] first;
    int          changed;
    int          pops;
    changed = 0; pops = 0;
    toc = 1'b0; rnw = 1'b0; code = 7'h20; addr = 7'h08; len = 8'd1; ready = 1'b1; pdone = 1'b0;
    en = 1'b1;
    tick;
    tick;
    n_checks++;
    if (tx_rd !== 1'b1) begin
      n_fail++; $display("FAIL bp_pop: got %b required 1", tx_rd);
    end
    tx_data = 16'h00FF; ready = 1'b0;
    tick;
    first = {word_valid, word};
    tx_data = 16'hDEAD;
    n_checks++;
    if (first !== {1'b1, 20'h803FD}) begin
      n_fail++; $display("FAIL bp_data_word: got %h required 1/803fd", first);
    end
    repeat (9) begin
      tick;
      if ({word_valid, word} !== first) changed++;
      pops += int'(tx_rd);
    end
    n_checks++;
    if (changed !== 0) begin
      n_fail++; $display("FAIL bp_word_stable: got %0d changes required 0", changed);
    end
    n_checks++;
    if (pops !== 0) begin
      n_fail++; $display("FAIL bp_extra_pop: got %0d pops required 0", pops);
    end
    ready = 1'b1;
    tick;
    n_checks++;
    if ({word_valid, word} !== {1'b1, 2'b01, 4'hC, tb_crc5(tb_crc5(5'h1F, 16'h2010), 16'h00FF), 9'b0}) begin
      n_fail++; $display("FAIL bp_crc_word: got %b/%h", word_valid, word);
    end
    tick;
    n_checks++;
    if ({restart_req, exit_req} !== 2'b10) begin
      n_fail++; $display("FAIL bp_restart: got restart=%b exit=%b required 10", restart_req, exit_req);
    end
    pdone = 1'b1;
    tick;
    en = 1'b0; pdone = 1'b0;
    tick;
  endtask

  task automatic test_abort;
    toc = 1'b0; rnw = 1'b0; code = 7'h20; addr = 7'h08; len = 8'd2; ready = 1'b0; pdone = 1'b0;
    en = 1'b1;
    tick;
    en = 1'b0; ready = 1'b1;
    tick;
    n_checks++;
    if ({exit_req, restart_req, tx_rd, word_valid} !== 4'b1000) begin
      n_fail++; $display("FAIL abort_term: got exit=%b restart=%b rd=%b vld=%b required 1000", exit_req, restart_req, tx_rd, word_valid);
    end
    n_checks++;
    if (err !== 3'b100) begin
      n_fail++; $display("FAIL abort_err: got %b required 100", err);
    end
    pdone = 1'b1;
    tick;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL abort_done: got %b required 1", done);
    end
    pdone = 1'b0;
    tick;
    n_checks++;
    if ({done, err} !== 4'b0100) begin
      n_fail++; $display("FAIL abort_idle: got done=%b err=%b required 0 100", done, err);
    end
  endtask

  task automatic test_reset_mid_read;
    toc = 1'b0; rnw = 1'b1; code = 7'h11; addr = 7'h22; len = 8'd3; ready = 1'b1; pdone = 1'b0;
    en = 1'b1;
    tick;
    tick;
    rx_word = {2'b10, 16'hC0DE, tb_par(16'hC0DE)}; rx_valid = 1'b1;
    tick;
    rx_valid = 1'b0;
    n_checks++;
    if ({rx_data_valid, rx_data} !== {1'b1, 16'hC0DE}) begin
      n_fail++; $display("FAIL rst_pre_data: got %b/%h required 1/c0de", rx_data_valid, rx_data);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({word_valid, word, tx_rd, rx_data, rx_data_valid, restart_req, exit_req, done, err} !== 45'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got rx=%h strobe=%b restart=%b exit=%b, required all zero", rx_data, rx_data_valid, restart_req, exit_req);
    end
    n_checks++;
    if (dut.state_q !== ST_IDLE) begin
      n_fail++; $display("FAIL rst_mid_state: got %0d required %0d", dut.state_q, ST_IDLE);
    end
    en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    n_checks++;
    if ({restart_req, exit_req, word_valid, done} !== 4'b0000 || dut.state_q !== ST_IDLE) begin
      n_fail++; $display("FAIL rst_mid_after: got restart=%b exit=%b vld=%b state=%0d required idle, no request", restart_req, exit_req, word_valid, dut.state_q);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read(1'b0);
    test_read(1'b1);
    test_len0;
    test_backpressure;
    test_abort;
    test_reset_mid_read;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1);
  end

endmodule
